// File: rtl/ray_dispatcher.sv
// Column ray dispatcher: issues one ray per column across NUM_PE lanes under credit flow control.
// Optional one-deep queued frame request when RAY_DISPATCH_PENDING_FRAME_EN is defined.

module ray_dispatch_lane #(
  parameter int LANE = 0,
  parameter int LW   = 2
)(
  input  logic [LW-1:0] last_grant,
  input  logic          ready,
  output logic          hi_req
);
  // Lanes above the last grant win before the search wraps around to lane 0.
  assign hi_req = ready && (LW'(LANE) > last_grant);
endmodule

module ray_dispatcher #(
  parameter int                 SCREEN_WIDTH = 640,
  parameter int                 NUM_PE       = 4,
  parameter logic signed [15:0] ANGLE_STEP   = 16'sd128,
  parameter int                 CREDITS      = 32
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic [15:0]       x_pos,
  input  logic [15:0]       y_pos,
  input  logic [15:0]       angle,
  input  logic [NUM_PE-1:0] pe_ready,
  output logic [NUM_PE-1:0] pe_start,
  output logic [15:0]       ray_x,
  output logic [15:0]       ray_y,
  output logic [15:0]       ray_angle,
  output logic [9:0]        ray_column,
  input  logic [NUM_PE-1:0] pe_done,
  input  logic              credit_return,
  output logic              frame_busy,
  output logic              frame_done
);
  localparam int         LW       = $clog2(NUM_PE);
  localparam int         CW       = $clog2(CREDITS + 1);
  localparam logic [9:0] LAST_COL = 10'(SCREEN_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LATCH, ISSUE, DRAIN} state_t;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] angle;
  } cam_t;

  state_t          state_q, state_d;
  cam_t            cam_q;
  logic [9:0]      col_q;
  logic [CW-1:0]   cred_q, cred_d;
  logic [10:0]     out_q, out_d;
  logic [11:0]     out_sum;
  logic [LW-1:0]   last_q, grant_idx;
  logic [NUM_PE-1:0] hi_req;
  logic            found;
  logic            issue;
  logic            last_column;
  logic [3:0]      done_cnt;
  logic            pend_q;
  logic signed [15:0] col_off;

  for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
    ray_dispatch_lane #(.LANE(i), .LW(LW)) u_lane (
      .last_grant (last_q),
      .ready      (pe_ready[i]),
      .hi_req     (hi_req[i])
    );
  end

  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_PE; i++)
      if (hi_req[i] && !found) begin
        grant_idx = LW'(i);
        found     = 1'b1;
      end
    for (int i = 0; i < NUM_PE; i++)
      if (pe_ready[i] && !found) begin
        grant_idx = LW'(i);
        found     = 1'b1;
      end
  end

  assign issue       = (state_q == ISSUE) && (cred_q != '0) && (|pe_ready);
  assign last_column = (col_q == LAST_COL);
  assign pe_start    = issue ? (NUM_PE'(1) << grant_idx) : '0;

  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < NUM_PE; i++)
      done_cnt = done_cnt + 4'(pe_done[i]);
  end

  // Completions without a matching issue are dropped by flooring at zero.
  assign out_sum = {1'b0, out_q} + 12'(issue);
  assign out_d   = (out_sum > 12'(done_cnt)) ? 11'(out_sum - 12'(done_cnt)) : '0;

  always_comb begin
    cred_d = cred_q;
    if (issue && !credit_return)
      cred_d = cred_q - CW'(1);
    else if (!issue && credit_return && (cred_q != CW'(CREDITS)))
      cred_d = cred_q + CW'(1);
  end

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    case (state_q)
      IDLE:  if (frame_start) state_d = LATCH;
      LATCH: state_d = ISSUE;
      ISSUE: if (issue && last_column) state_d = DRAIN;
      DRAIN: if (out_q == '0) begin
        frame_done = 1'b1;
        state_d    = pend_q ? LATCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign frame_busy = (state_q != IDLE) && !(frame_done && !pend_q);

`ifdef RAY_DISPATCH_PENDING_FRAME_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         pend_q <= 1'b0;
    else if (frame_done)                pend_q <= 1'b0;
    else if (frame_start && frame_busy) pend_q <= 1'b1;
  end
`else
  assign pend_q = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cam_q   <= '0;
      col_q   <= '0;
      cred_q  <= CW'(CREDITS);
      out_q   <= '0;
      last_q  <= LW'(NUM_PE - 1);
    end else begin
      state_q <= state_d;
      cred_q  <= cred_d;
      out_q   <= out_d;
      if (state_q == LATCH) begin
        cam_q <= cam_t'{x: x_pos, y: y_pos, angle: angle};
        col_q <= '0;
      end else if (issue && !last_column) begin
        col_q <= col_q + 10'd1;
      end
      if (issue) last_q <= grant_idx;
    end
  end

  // Angle offset relative to screen centre; low 16 bits give two's-complement wrap.
  assign col_off    = signed'(16'(col_q)) - signed'(16'(SCREEN_WIDTH / 2));
  assign ray_angle  = cam_q.angle + 16'(col_off * ANGLE_STEP);
  assign ray_x      = cam_q.x;
  assign ray_y      = cam_q.y;
  assign ray_column = col_q;

endmodule

// File: tb/tb_ray_dispatcher.sv
// Self-checking bench for ray_dispatcher: directed vector table, corner sequences, random vs reference model.
module tb_ray_dispatcher;
  localparam int W = 8, N = 4, C = 32, STEP = 128;
  localparam int P_IDLE = 0, P_LATCH = 1, P_ISSUE = 2, P_DRAIN = 3;

  logic clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0, credit_return = 1'b0;
  logic [15:0] x_pos = '0, y_pos = '0, angle = '0;
  logic [3:0] pe_ready = '0, pe_done = '0, pe_start;
  logic [15:0] ray_x, ray_y, ray_angle;
  logic [9:0] ray_column;
  logic frame_busy, frame_done;

  ray_dispatcher #(.SCREEN_WIDTH(W), .NUM_PE(N), .ANGLE_STEP(16'sd128), .CREDITS(C)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .x_pos(x_pos), .y_pos(y_pos), .angle(angle),
    .pe_ready(pe_ready), .pe_start(pe_start),
    .ray_x(ray_x), .ray_y(ray_y), .ray_angle(ray_angle), .ray_column(ray_column),
    .pe_done(pe_done), .credit_return(credit_return),
    .frame_busy(frame_busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [15:0] cx = '0, cy = '0, ca = '0;

  // Reference model: abstract frame phase plus counts.
  int m_phase, m_col, m_cred, m_out, m_last;
  bit m_pend;
  logic [15:0] m_x, m_y, m_ang;
  bit e_issue, e_done, e_busy;
  int e_lane;
  logic [3:0] e_start;

  typedef struct {
    logic [3:0]  rdy;
    logic        cr;
    logic [3:0]  start;
    int          col;
    logic [15:0] ang;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_col = 0; m_cred = C; m_out = 0; m_last = N - 1; m_pend = 0;
    m_x = '0; m_y = '0; m_ang = '0;
  endtask

  function automatic logic [15:0] exp_ang();
    int a;
    a = int'(m_ang) + (m_col - W / 2) * STEP;
    return a[15:0];
  endfunction

  task automatic model_eval();
    e_issue = (m_phase == P_ISSUE) && (m_cred > 0) && (pe_ready != 0);
    e_lane = -1;
    for (int k = 1; k <= N; k++) begin
      int cand;
      cand = (m_last + k) % N;
      if (e_lane < 0 && pe_ready[cand]) e_lane = cand;
    end
    e_start = e_issue ? 4'(1 << e_lane) : 4'b0;
    e_done  = (m_phase == P_DRAIN) && (m_out == 0);
    e_busy  = (m_phase != P_IDLE) && !(e_done && !m_pend);
  endtask

  task automatic check_all();
    model_eval();
    chk("pe_start", 32'(pe_start), 32'(e_start));
    chk("ray_column", 32'(ray_column), m_col);
    chk("ray_angle", 32'(ray_angle), 32'(exp_ang()));
    chk("ray_x", 32'(ray_x), 32'(m_x));
    chk("ray_y", 32'(ray_y), 32'(m_y));
    chk("frame_busy", 32'(frame_busy), 32'(e_busy));
    chk("frame_done", 32'(frame_done), 32'(e_done));
  endtask

  task automatic model_step();
    int o;
    bit np;
    o = m_out + (e_issue ? 1 : 0) - $countones(pe_done);
    m_out = (o < 0) ? 0 : o;
    if (e_issue && !credit_return) m_cred--;
    else if (!e_issue && credit_return && m_cred < C) m_cred++;
    np = m_pend;
`ifdef RAY_DISPATCH_PENDING_FRAME_EN
    if (e_done) np = 0;
    else if (frame_start && e_busy) np = 1;
`endif
    case (m_phase)
      P_IDLE:  if (frame_start) m_phase = P_LATCH;
      P_LATCH: begin
        m_x = x_pos; m_y = y_pos; m_ang = angle; m_col = 0; m_phase = P_ISSUE;
      end
      P_ISSUE: if (e_issue) begin
        m_last = e_lane;
        if (m_col == W - 1) m_phase = P_DRAIN;
        else m_col++;
      end
      default: if (e_done) m_phase = m_pend ? P_LATCH : P_IDLE;
    endcase
    m_pend = np;
  endtask

  task automatic cyc(input bit f, input logic [3:0] r, input logic [3:0] d, input bit c);
    @(negedge clk);
    frame_start = f; pe_ready = r; pe_done = d; credit_return = c;
    x_pos = cx; y_pos = cy; angle = ca;
    #1;
    check_all();
    model_step();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1; frame_start = 1'b0; pe_ready = 4'hF; pe_done = 4'b0101; credit_return = 1'b0;
    #1;
    check_all();
    model_step();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_pe_start", 32'(pe_start), 0);
    chk("rst_busy", 32'(frame_busy), 0);
    release_reset();
  endtask

  task automatic finish_frame(input logic [3:0] r, input logic [3:0] d, input bit c);
    int n;
    n = 0;
    while (m_phase != P_IDLE && n < 200) begin
      cyc(0, r, d, c);
      n++;
    end
    chk("frame_timeout", 32'(n < 200), 1);
  endtask

  task automatic run_frame(input logic [3:0] r, input bit c, input logic [3:0] d);
    cyc(1, r, 4'b0, c);
    finish_frame(r, d, c);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dn_cnt;
    tbl[0] = '{4'hF, 1'b0, 4'b0001, 0, 16'h0E00};
    tbl[1] = '{4'hF, 1'b0, 4'b0010, 1, 16'h0E80};
    tbl[2] = '{4'hF, 1'b1, 4'b0100, 2, 16'h0F00};
    tbl[3] = '{4'hF, 1'b1, 4'b1000, 3, 16'h0F80};
    tbl[4] = '{4'hF, 1'b1, 4'b0001, 4, 16'h1000};
    tbl[5] = '{4'hF, 1'b1, 4'b0010, 5, 16'h1080};
    tbl[6] = '{4'hF, 1'b1, 4'b0100, 6, 16'h1100};
    tbl[7] = '{4'hF, 1'b1, 4'b1000, 7, 16'h1180};

    // Reset state
    #3;
    model_reset();
    check_all();
    chk("reset_angle", 32'(ray_angle), 32'h0000FE00);
    release_reset();

    // Frame 1: directed table, camera changes after LATCH must not leak into rays
    cx = 16'h1234; cy = 16'h5678; ca = 16'h1000;
    cyc(1, 4'hF, 4'b0, 1'b0);
    cyc(0, 4'hF, 4'b0, 1'b0);
    cx = 16'hDEAD; cy = 16'hBEEF; ca = 16'h7777;
    for (int i = 0; i < 8; i++) begin
      cyc(0, tbl[i].rdy, 4'b0, tbl[i].cr);
      chk("tbl_start", 32'(pe_start), 32'(tbl[i].start));
      chk("tbl_col", 32'(ray_column), tbl[i].col);
      chk("tbl_angle", 32'(ray_angle), 32'(tbl[i].ang));
      chk("tbl_x", 32'(ray_x), 32'h1234);
    end
    // Drain with two completions in one cycle
    cyc(0, 4'hF, 4'b0011, 1'b0); chk("drain_nodone1", 32'(frame_done), 0);
    cyc(0, 4'hF, 4'b1111, 1'b0); chk("drain_nodone2", 32'(frame_done), 0);
    cyc(0, 4'hF, 4'b0101, 1'b0); chk("drain_nodone3", 32'(frame_done), 0);
    cyc(0, 4'hF, 4'b0000, 1'b0);
    chk("drain_done", 32'(frame_done), 1);
    chk("drain_busy_fall", 32'(frame_busy), 0);
    cyc(0, 4'hF, 4'b0000, 1'b0); chk("drain_done_once", 32'(frame_done), 0);

    // Frames 2-4 consume credits without returns (30 -> 6)
    for (int f = 0; f < 3; f++) run_frame(4'hF, 1'b0, 4'hF);

    // Frame 5: credits run out mid-frame
    cyc(1, 4'hF, 4'b0, 1'b0);
    cyc(0, 4'hF, 4'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(0, 4'hF, 4'b0, 1'b0);
    cyc(0, 4'hF, 4'b0, 1'b0); chk("cred_a", 32'(pe_start), 32'b0001); chk("cred_a_col", 32'(ray_column), 4);
    cyc(0, 4'hF, 4'b0, 1'b0); chk("cred_b", 32'(pe_start), 32'b0010); chk("cred_b_col", 32'(ray_column), 5);
    cyc(0, 4'hF, 4'b0, 1'b0); chk("cred_stall", 32'(pe_start), 0);    chk("cred_stall_col", 32'(ray_column), 6);
    cyc(0, 4'hF, 4'b0, 1'b1); chk("cred_ret", 32'(pe_start), 0);
    cyc(0, 4'hF, 4'b0, 1'b0); chk("cred_one", 32'(pe_start), 32'b0100); chk("cred_one_col", 32'(ray_column), 6);
    cyc(0, 4'hF, 4'b0, 1'b0); chk("cred_stall2", 32'(pe_start), 0);   chk("cred_stall2_col", 32'(ray_column), 7);
    finish_frame(4'hF, 4'hF, 1'b1);
    repeat (40) cyc(0, 4'h0, 4'h0, 1'b1);

    // Frame 6: single ready lane, then no lanes ready
    cyc(1, 4'b0100, 4'b0, 1'b1);
    cyc(0, 4'b0100, 4'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 4'b0100, 4'b0, 1'b1);
      chk("lane2_start", 32'(pe_start), 32'b0100);
      chk("lane2_col", 32'(ray_column), i);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 4'b0000, 4'b0, 1'b1);
      chk("noready_start", 32'(pe_start), 0);
      chk("noready_hold", 32'(ray_column), 3);
    end
    finish_frame(4'b0100, 4'b0100, 1'b1);

    // Frame 7: frame_start while issuing
    dn_cnt = 0;
    cyc(1, 4'hF, 4'b0, 1'b1);
    cyc(0, 4'hF, 4'b0, 1'b1);
    cyc(1, 4'hF, 4'b0, 1'b1);
    for (int n = 0; n < 200 && m_phase != P_IDLE; n++) begin
      cyc(0, 4'hF, 4'hF, 1'b1);
      if (frame_done) dn_cnt++;
    end
`ifdef RAY_DISPATCH_PENDING_FRAME_EN
    chk("pending_frames", dn_cnt, 2);
`else
    chk("pending_frames", dn_cnt, 1);
`endif

    // Frame 8: reset mid-issue, then restart from column 0 lane 0
    cx = 16'h0101; cy = 16'h0202; ca = 16'h8000;
    cyc(1, 4'hF, 4'b0, 1'b1);
    cyc(0, 4'hF, 4'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(0, 4'b0110, 4'b0, 1'b1);
    apply_reset();
    cyc(1, 4'hF, 4'b0, 1'b1);
    cyc(0, 4'hF, 4'b0, 1'b1);
    cyc(0, 4'hF, 4'b0, 1'b1);
    chk("restart_lane", 32'(pe_start), 32'b0001);
    chk("restart_col", 32'(ray_column), 0);
    finish_frame(4'hF, 4'hF, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      cx = 16'($urandom); cy = 16'($urandom); ca = 16'($urandom);
      if ($urandom_range(0, 399) == 0) apply_reset();
      else cyc(($urandom_range(0, 15) == 0), 4'($urandom), 4'($urandom & $urandom),
               1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ray_dispatcher.md
RAY_DISPATCHER -- requirements
Module: ray_dispatcher

Interface
REQ-001 Parameter SCREEN_WIDTH, default 640, number of columns issued per frame (max 1024).
REQ-002 Parameter NUM_PE, default 4, number of process_element lanes served (2..8).
REQ-003 Parameter ANGLE_STEP, default 128, signed 16-bit per-column angle increment.
REQ-004 Parameter CREDITS, default 32, downstream column-buffer slots available at reset.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 frame_start  in  1  single-cycle request to render one frame.
REQ-008 x_pos, y_pos, angle  in  16 each  camera state; sampled only in LATCH.
REQ-009 pe_ready  in  NUM_PE  lane i idle and able to accept a ray.
REQ-010 pe_start  out  NUM_PE  one-hot (or zero) issue strobe to lane i.
REQ-011 ray_x, ray_y, ray_angle  out  16 each  ray parameters, valid in the pe_start cycle.
REQ-012 ray_column  out  10  column index of the issued ray.
REQ-013 pe_done  in  NUM_PE  lane i completed one ray; any subset may assert per cycle.
REQ-014 credit_return  in  1  downstream freed one column slot.
REQ-015 frame_busy  out  1  high from LATCH entry until frame_done.
REQ-016 frame_done  out  1  single-cycle pulse when last ray of frame has completed.

Function
REQ-017 FSM states IDLE, LATCH, ISSUE, DRAIN; IDLE->LATCH on frame_start; LATCH->ISSUE after one cycle; ISSUE->DRAIN in the cycle column SCREEN_WIDTH-1 is issued; DRAIN->IDLE when outstanding==0, pulsing frame_done in that transition cycle.
REQ-018 LATCH captures x_pos, y_pos, angle and clears the column counter to 0; ray outputs use latched values for the whole frame.
REQ-019 In ISSUE, one ray is issued per cycle iff credits>0 and at least one pe_ready bit is set; otherwise pe_start=0 and the column counter holds.
REQ-020 Lane selection is round-robin: search starts at lane after last-granted lane, wraps at NUM_PE-1->0; after reset last-granted = NUM_PE-1 (lane 0 first).
REQ-021 Column counter increments by 1 per issue; never exceeds SCREEN_WIDTH-1.
REQ-022 ray_angle = latched angle + (ray_column - SCREEN_WIDTH/2)*ANGLE_STEP, computed signed, truncated to 16 bits (two's-complement wrap); ray_* outputs combinational from counter and latched state, zero-latency with pe_start.
REQ-023 Credit counter: -1 on issue, +1 on credit_return, unchanged on both; saturates at CREDITS (excess returns ignored).
REQ-024 Outstanding counter: +1 on issue, minus popcount(pe_done) same cycle; pe_done on a lane with nothing outstanding is a protocol error, counter floors at 0.
REQ-025 frame_start in LATCH, ISSUE or DRAIN is handled per REQ-030/031.

Reset
REQ-026 rst_n low: state IDLE, counters 0, credits = CREDITS, last-granted = NUM_PE-1, latched camera 0.
REQ-027 Outputs during reset: pe_start=0, frame_busy=0, frame_done=0, ray_* =0 except ray_angle per REQ-022 with zeroed state.
REQ-028 Reset mid-frame abandons the frame; no frame_done is produced; in-flight pe_done after release is floored per REQ-024.
REQ-029 Deassertion is used synchronously by the design's first clock edge; no issue in the release cycle.

Configuration
REQ-030 Macro RAY_DISPATCH_PENDING_FRAME_EN defined: frame_start while frame_busy sets a one-deep pending flag; on frame_done the FSM goes DRAIN->LATCH directly (frame_busy stays high) and clears the flag; further requests while pending are dropped.
REQ-031 Macro undefined: frame_start while frame_busy is ignored; no pending flag exists.

Verification
REQ-032 SCREEN_WIDTH=8, NUM_PE=4, all ready, CREDITS=32, angle=0x1000: frame_start -> pe_start 0001,0010,0100,1000,0001... columns 0..7 consecutive cycles, ray_angle first = 0x1000-4*128 = 0x0E00.
REQ-033 Credits=2, no credit_return -> exactly 2 issues then stall; one credit_return -> exactly one further issue next cycle.
REQ-034 pe_ready=0100 only -> every issue goes to lane 2; pe_ready toggled to 0000 -> counter holds, no pe_start.
REQ-035 Last column issued, pe_done arrives for all lanes incl. two in one cycle -> frame_done pulses exactly once when outstanding reaches 0, frame_busy falls same cycle.
REQ-036 frame_start during ISSUE -> with macro: second frame starts immediately after frame_done, frame_busy never drops; without: ignored, FSM returns to IDLE.
REQ-037 rst_n asserted mid-ISSUE -> pe_start=0, credits restored to CREDITS asynchronously, next frame_start restarts at column 0 lane 0.
